// File: rtl/npu_mem_pkg.sv
// Shared types and default sizing for the NPU memory loader.
//   loader_state_t : loader FSM states; the encoding is visible on the region port
//   BYTE_W, *_DEF  : default element width, bank count, region depths and address width
package npu_mem_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned NUM_BANKS_DEF   = 4;
    localparam int unsigned IMG_DEPTH_DEF   = 225;
    localparam int unsigned CONV_DEPTH_DEF  = 18816;
    localparam int unsigned DENSE_DEPTH_DEF = 16746;
    localparam int unsigned BIAS_DEPTH_DEF  = 10;
    localparam int unsigned ADDR_W_DEF      = 15;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_IMG   = 3'd1,
        ST_LOAD_CONV  = 3'd2,
        ST_LOAD_DENSE = 3'd3,
        ST_LOAD_BIAS  = 3'd4,
        ST_DONE       = 3'd5
    } loader_state_t;

    // True for the four states that accept host words.
    function automatic logic is_load(loader_state_t s);
        return (s == ST_LOAD_IMG) || (s == ST_LOAD_CONV) ||
               (s == ST_LOAD_DENSE) || (s == ST_LOAD_BIAS);
    endfunction

    // Fixed region order: IMG -> CONV -> DENSE -> BIAS -> DONE.
    function automatic loader_state_t next_region(loader_state_t s);
        case (s)
            ST_LOAD_IMG:   return ST_LOAD_CONV;
            ST_LOAD_CONV:  return ST_LOAD_DENSE;
            ST_LOAD_DENSE: return ST_LOAD_BIAS;
            default:       return ST_DONE;
        endcase
    endfunction

endpackage

// File: rtl/npu_region_counter.sv
// Per-region element counter for the memory loader.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : return to 0 (has priority over inc_i)
//   inc_i      : advance by one element
//   last_idx_i : index of the final element of the current region
//   count_o    : current element index (registered)
//   last_c_o   : combinational flag, count_o equals last_idx_i
module npu_region_counter #(
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] last_idx_i,
    output logic [ADDR_W-1:0] count_o,
    output logic              last_c_o
);

    logic [ADDR_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset)      count_q <= '0;
        else if (clr_i) count_q <= '0;
        else if (inc_i) count_q <= count_q + ADDR_W'(1);
    end

    assign count_o  = count_q;
    assign last_c_o = (count_q == last_idx_i);

endmodule

// File: rtl/npu_mem_loader.sv
// Bulk loader that streams host words into the image banks, then the conv,
// dense and bias RAMs, in that fixed order, after a start pulse.
//   clk, reset          : clock, synchronous active-high reset
//   start               : begins a load sequence from IDLE or DONE
//   wr_valid/writedata  : host word stream; wr_ready signals acceptance
//   img_we/data/addr    : image banks; bank k sits at img_data[k*BYTE_W +: BYTE_W]
//                         and receives the k-th byte counted from the MSB of the word
//   conv_*/dense_*/bias_*: single-element write ports of each RAM
//   busy, done, region  : status (region is the state encoding)
// Optional build macro NPU_MEM_LOADER_PACK_EN: conv/dense/bias take NUM_BANKS
// elements per word, MSB byte first, serialised one element per cycle.
module npu_mem_loader #(
    parameter int unsigned BYTE_W      = npu_mem_pkg::BYTE_W,
    parameter int unsigned NUM_BANKS   = npu_mem_pkg::NUM_BANKS_DEF,
    parameter int unsigned IMG_DEPTH   = npu_mem_pkg::IMG_DEPTH_DEF,
    parameter int unsigned CONV_DEPTH  = npu_mem_pkg::CONV_DEPTH_DEF,
    parameter int unsigned DENSE_DEPTH = npu_mem_pkg::DENSE_DEPTH_DEF,
    parameter int unsigned BIAS_DEPTH  = npu_mem_pkg::BIAS_DEPTH_DEF,
    parameter int unsigned ADDR_W      = npu_mem_pkg::ADDR_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        wr_valid,
    input  logic [NUM_BANKS*BYTE_W-1:0] writedata,
    output logic                        wr_ready,
    output logic [NUM_BANKS-1:0]        img_we,
    output logic [NUM_BANKS*BYTE_W-1:0] img_data,
    output logic [ADDR_W-1:0]           img_addr,
    output logic                        conv_we,
    output logic [BYTE_W-1:0]           conv_data,
    output logic [ADDR_W-1:0]           conv_addr,
    output logic                        dense_we,
    output logic [BYTE_W-1:0]           dense_data,
    output logic [ADDR_W-1:0]           dense_addr,
    output logic                        bias_we,
    output logic [BYTE_W-1:0]           bias_data,
    output logic [ADDR_W-1:0]           bias_addr,
    output logic                        busy,
    output logic                        done,
    output logic [2:0]                  region
);

    import npu_mem_pkg::*;

    localparam int unsigned DATA_W = NUM_BANKS * BYTE_W;

    loader_state_t     state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d, rdy_q, rdy_d;
    logic              accept_c, issue_c, wr_en_c;
    logic              cnt_clr_c, cnt_inc_c, cnt_last_c;
    logic [ADDR_W-1:0] cnt_c, last_idx_c;
    logic [DATA_W-1:0] img_word_c;
    logic [BYTE_W-1:0] wr_byte_c;

    logic [NUM_BANKS-1:0] img_we_q;
    logic [DATA_W-1:0]    img_data_q;
    logic [ADDR_W-1:0]    img_addr_q, conv_addr_q, dense_addr_q, bias_addr_q;
    logic                 conv_we_q, dense_we_q, bias_we_q;
    logic [BYTE_W-1:0]    conv_data_q, dense_data_q, bias_data_q;

`ifdef NPU_MEM_LOADER_PACK_EN
    localparam int unsigned PEND_W = $clog2(NUM_BANKS) + 1;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [DATA_W-1:0] word_q, word_d, src_word_c;
`endif

    npu_region_counter #(.ADDR_W(ADDR_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (cnt_clr_c),
        .inc_i      (cnt_inc_c),
        .last_idx_i (last_idx_c),
        .count_o    (cnt_c),
        .last_c_o   (cnt_last_c)
    );

    assign accept_c = wr_valid & rdy_q;

    // Byte-split of the host word: bank 0 receives the MSB byte.
    always_comb begin
        img_word_c = '0;
        for (int k = 0; k < int'(NUM_BANKS); k++) begin
            img_word_c[k*BYTE_W +: BYTE_W] = writedata[(int'(NUM_BANKS)-1-k)*BYTE_W +: BYTE_W];
        end
    end

    // State register and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

`ifdef NPU_MEM_LOADER_PACK_EN
    // Holding register for the bytes of a word still being serialised.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            word_q <= '0;
        end else begin
            pend_q <= pend_d;
            word_q <= word_d;
        end
    end
`endif

    // Next-state, counter control and write-issue decode.
    always_comb begin
        state_d    = state_q;
        cnt_clr_c  = 1'b0;
        cnt_inc_c  = 1'b0;
        wr_en_c    = 1'b0;
        last_idx_c = '0;
`ifdef NPU_MEM_LOADER_PACK_EN
        pend_d     = pend_q;
        word_d     = word_q;
        src_word_c = (pend_q != '0) ? word_q : writedata;
        wr_byte_c  = src_word_c[DATA_W-1 -: BYTE_W];
        issue_c    = accept_c | (pend_q != '0);
`else
        wr_byte_c  = writedata[BYTE_W-1:0];
        issue_c    = accept_c;
`endif

        case (state_q)
            ST_LOAD_IMG:   last_idx_c = ADDR_W'(IMG_DEPTH - 1);
            ST_LOAD_CONV:  last_idx_c = ADDR_W'(CONV_DEPTH - 1);
            ST_LOAD_DENSE: last_idx_c = ADDR_W'(DENSE_DEPTH - 1);
            ST_LOAD_BIAS:  last_idx_c = ADDR_W'(BIAS_DEPTH - 1);
            default:       last_idx_c = '0;
        endcase

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_LOAD_IMG;
                    cnt_clr_c = 1'b1;
                end
            end
            default: begin
                if (issue_c) begin
                    wr_en_c = 1'b1;
                    if (cnt_last_c) begin
                        state_d   = next_region(state_q);
                        cnt_clr_c = 1'b1;
                    end else begin
                        cnt_inc_c = 1'b1;
                    end
`ifdef NPU_MEM_LOADER_PACK_EN
                    // Region end drops any bytes left in the current word.
                    if (state_q != ST_LOAD_IMG) begin
                        if (cnt_last_c)    pend_d = '0;
                        else if (accept_c) pend_d = PEND_W'(NUM_BANKS - 1);
                        else               pend_d = pend_q - PEND_W'(1);
                        word_d = src_word_c << BYTE_W;
                    end
`endif
                end
            end
        endcase

        busy_d = is_load(state_d);
        done_d = (state_d == ST_DONE);
`ifdef NPU_MEM_LOADER_PACK_EN
        rdy_d  = busy_d && (pend_d == '0);
`else
        rdy_d  = busy_d;
`endif
    end

    // Write ports: one-cycle enable pulses; data/addr hold between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            img_we_q     <= '0;
            img_data_q   <= '0;
            img_addr_q   <= '0;
            conv_we_q    <= 1'b0;
            conv_data_q  <= '0;
            conv_addr_q  <= '0;
            dense_we_q   <= 1'b0;
            dense_data_q <= '0;
            dense_addr_q <= '0;
            bias_we_q    <= 1'b0;
            bias_data_q  <= '0;
            bias_addr_q  <= '0;
        end else begin
            img_we_q   <= {NUM_BANKS{wr_en_c && (state_q == ST_LOAD_IMG)}};
            conv_we_q  <= wr_en_c && (state_q == ST_LOAD_CONV);
            dense_we_q <= wr_en_c && (state_q == ST_LOAD_DENSE);
            bias_we_q  <= wr_en_c && (state_q == ST_LOAD_BIAS);
            if (wr_en_c && (state_q == ST_LOAD_IMG)) begin
                img_data_q <= img_word_c;
                img_addr_q <= cnt_c;
            end
            if (wr_en_c && (state_q == ST_LOAD_CONV)) begin
                conv_data_q <= wr_byte_c;
                conv_addr_q <= cnt_c;
            end
            if (wr_en_c && (state_q == ST_LOAD_DENSE)) begin
                dense_data_q <= wr_byte_c;
                dense_addr_q <= cnt_c;
            end
            if (wr_en_c && (state_q == ST_LOAD_BIAS)) begin
                bias_data_q <= wr_byte_c;
                bias_addr_q <= cnt_c;
            end
        end
    end

    assign wr_ready   = rdy_q;
    assign img_we     = img_we_q;
    assign img_data   = img_data_q;
    assign img_addr   = img_addr_q;
    assign conv_we    = conv_we_q;
    assign conv_data  = conv_data_q;
    assign conv_addr  = conv_addr_q;
    assign dense_we   = dense_we_q;
    assign dense_data = dense_data_q;
    assign dense_addr = dense_addr_q;
    assign bias_we    = bias_we_q;
    assign bias_data  = bias_data_q;
    assign bias_addr  = bias_addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign region     = 3'(state_q);

endmodule

// File: tb/tb_npu_mem_loader.sv
// Self-checking bench for npu_mem_loader with small region depths.
// Words accepted by the DUT are logged; a region-fill model turns the log
// into the expected write list, which is compared with the observed writes.
module tb_npu_mem_loader;

    localparam int NB      = 4;
    localparam int BW      = 8;
    localparam int AW      = 15;
    localparam int IMG_D   = 3;
    localparam int CONV_D  = 6;
    localparam int DENSE_D = 2;
    localparam int BIAS_D  = 1;

    logic              clk = 1'b0;
    logic              reset, start, wr_valid, wr_ready;
    logic [NB*BW-1:0]  writedata, img_data;
    logic [NB-1:0]     img_we;
    logic [AW-1:0]     img_addr, conv_addr, dense_addr, bias_addr;
    logic              conv_we, dense_we, bias_we, busy, done;
    logic [BW-1:0]     conv_data, dense_data, bias_data;
    logic [2:0]        region;

    npu_mem_loader #(
        .BYTE_W(BW), .NUM_BANKS(NB), .IMG_DEPTH(IMG_D), .CONV_DEPTH(CONV_D),
        .DENSE_DEPTH(DENSE_D), .BIAS_DEPTH(BIAS_D), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .wr_valid(wr_valid),
        .writedata(writedata), .wr_ready(wr_ready),
        .img_we(img_we), .img_data(img_data), .img_addr(img_addr),
        .conv_we(conv_we), .conv_data(conv_data), .conv_addr(conv_addr),
        .dense_we(dense_we), .dense_data(dense_data), .dense_addr(dense_addr),
        .bias_we(bias_we), .bias_data(bias_data), .bias_addr(bias_addr),
        .busy(busy), .done(done), .region(region)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rg;
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         obs_q[$];
    wr_t         exp_q[$];
    logic [31:0] acc_q[$];
    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 0;
    bit          pend_tb = 0;

`ifdef NPU_MEM_LOADER_PACK_EN
    localparam bit PACK = 1'b1;
`else
    localparam bit PACK = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic int depth_of(input int r);
        case (r)
            1: return IMG_D;
            2: return CONV_D;
            3: return DENSE_D;
            default: return BIAS_D;
        endcase
    endfunction

    function automatic int words_needed();
        int n = IMG_D;
        for (int r = 2; r <= 4; r++) n += PACK ? (depth_of(r) + NB - 1) / NB : depth_of(r);
        return n;
    endfunction

    // Fill regions in order from the accepted word log.
    function automatic void build_exp();
        int r = 1;
        int idx = 0;
        wr_t e;
        exp_q.delete();
        foreach (acc_q[i]) begin
            logic [31:0] w = acc_q[i];
            if (r == 1) begin
                e.rg = 1; e.addr = idx;
                for (int k = 0; k < NB; k++) e.data[k*8 +: 8] = w[(NB-1-k)*8 +: 8];
                exp_q.push_back(e);
                idx++;
                if (idx == IMG_D) begin r = 2; idx = 0; end
            end else if (r <= 4) begin
                int nel = PACK ? NB : 1;
                for (int b = 0; b < nel; b++) begin
                    if (r <= 4) begin
                        e.rg = r; e.addr = idx;
                        e.data = PACK ? {24'h0, w[31-8*b -: 8]} : {24'h0, w[7:0]};
                        exp_q.push_back(e);
                        idx++;
                        if (idx == depth_of(r)) begin r++; idx = 0; b = nel; end
                    end
                end
            end
        end
    endfunction

    task automatic compare_writes(input string tag);
        build_exp();
        check({tag, "_nwr"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_rg%0d", tag, i), obs_q[i].rg, exp_q[i].rg);
            check($sformatf("%s_addr%0d", tag, i), obs_q[i].addr, exp_q[i].addr);
            check($sformatf("%s_data%0d", tag, i), obs_q[i].data, exp_q[i].data);
        end
    endtask

    // Write monitor and accept logger, sampled mid-cycle.
    always @(negedge clk) begin
        wr_t o;
        logic any;
        any = (|img_we) | conv_we | dense_we | bias_we;
        if (mon_en) begin
            if (!PACK) check("we_timing", 32'(any), 32'(pend_tb));
            if (any) check("we_onehot", 32'($countones({|img_we, conv_we, dense_we, bias_we})), 1);
            if (|img_we) begin
                check("img_we_all", 32'(img_we), 32'hF);
                o.rg = 1; o.addr = int'(img_addr); o.data = img_data; obs_q.push_back(o);
            end
            if (conv_we)  begin o.rg = 2; o.addr = int'(conv_addr);  o.data = {24'h0, conv_data};  obs_q.push_back(o); end
            if (dense_we) begin o.rg = 3; o.addr = int'(dense_addr); o.data = {24'h0, dense_data}; obs_q.push_back(o); end
            if (bias_we)  begin o.rg = 4; o.addr = int'(bias_addr);  o.data = {24'h0, bias_data};  obs_q.push_back(o); end
        end
        pend_tb = (wr_valid === 1'b1) && (wr_ready === 1'b1) && (reset === 1'b0);
        if (pend_tb) acc_q.push_back(writedata);
    end

    task automatic do_start();
        obs_q.delete();
        acc_q.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit expect_acc, input int gap);
        bit got = 0;
        repeat (gap) begin @(posedge clk); #1; end
        wr_valid  = 1'b1;
        writedata = w;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (wr_ready === 1'b1) got = 1;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        check(expect_acc ? "word_accept" : "word_drop", 32'(got), 32'(expect_acc));
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_region"}, 32'(region), 5);
        check({tag, "_ready"}, 32'(wr_ready), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_seq(input string tag, input int gap, input bit fixed_first, input int pulse_at);
        int need = words_needed();
        do_start();
        for (int i = 0; i < need; i++) begin
            logic [31:0] w = $urandom;
            if (fixed_first && i == 0) w = 32'hA0B1C2D3;
            if (PACK && i == IMG_D) w = 32'h11223344;
            send_word(w, 1'b1, gap);
            if (PACK && i == IMG_D) begin
                int low = 0;
                bit seen = 0;
                for (int c = 0; c < 10 && !seen; c++) begin
                    @(negedge clk);
                    if (wr_ready === 1'b1) seen = 1; else low++;
                    @(posedge clk); #1;
                end
                check({tag, "_pack_ready_low"}, 32'(low), NB - 1);
            end
            if (i == pulse_at) begin
                check({tag, "_region_conv"}, 32'(region), 2);
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        send_word($urandom, 1'b0, 0);
        send_word($urandom, 1'b0, 1);
        repeat (3) begin @(posedge clk); #1; end
        check_done(tag);
        compare_writes(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; wr_valid = 1'b0; writedata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;

        // Idle after reset: everything quiet.
        repeat (5) begin
            @(negedge clk);
            check("idle_flags", {26'h0, busy, done, wr_ready, conv_we, dense_we, bias_we}, 0);
            check("idle_img", {img_we, img_addr, img_data[12:0]}, 0);
            check("idle_region", 32'(region), 0);
        end
        @(posedge clk); #1;

        // Back-to-back load, first word fixed.
        run_seq("b2b", 0, 1'b1, -1);
        check("b2b_bank0", obs_q.size() > 0 ? 32'(obs_q[0].data[7:0]) : 32'hX, 32'hA0);
        check("b2b_bank3", obs_q.size() > 0 ? 32'(obs_q[0].data[31:24]) : 32'hX, 32'hD3);

        // Valid gaps between words.
        run_seq("gap", 1, 1'b0, -1);

        // Reset after the fourth accepted word.
        do_start();
        for (int i = 0; i < 4; i++) send_word($urandom, 1'b1, 0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_region", 32'(region), 0);
        check("rst_we", 32'({img_we, conv_we, dense_we, bias_we}), 0);
        check("rst_busy", 32'({busy, done, wr_ready}), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_seq("reload", 0, 1'b0, -1);

        // start pulse during the conv region is ignored.
        run_seq("startconv", 0, 1'b0, IMG_D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
